uart_tx: RTL and testbench

//  Serial transmitter driving the top-level tx_serial pin; counterpart of the rx_serial receive path.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic        UART_IDLE_LEVEL = 1'b1;
    localparam int unsigned UART_DATA_BITS  = 8;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; full/empty flags are registered.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push_i,
    input  logic [UART_DATA_BITS-1:0] wdata_i,
    input  logic                      pop_i,
    output logic [UART_DATA_BITS-1:0] rdata_c,
    output logic                      full_o,
    output logic                      empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
    logic                      full_q, empty_q;
    logic                      do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                        (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
            empty_q  <= (wr_ptr_d == rd_ptr_d);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO plus 8N1 framer, LSB first, back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [UART_DATA_BITS-1:0] data_in,
    input  logic                      write_en,
    output logic                      ready,
    output logic                      tx_serial,
    output logic                      busy,
    output logic                      overflow
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

    tx_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, overflow_q;

    logic                      fifo_full, fifo_empty, push, pop_c;
    logic [UART_DATA_BITS-1:0] fifo_rdata;
    logic                      baud_done, bit_last;

    assign push = write_en && !fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (data_in),
        .pop_i   (pop_c),
        .rdata_c (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign bit_last  = (bit_q == BIT_W'(UART_DATA_BITS - 1));

    // Next-state, counters and line level; tx_d is the level for the current state.
    always_comb begin
        state_d = state_q;
        cnt_d   = baud_done ? '0 : cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = UART_IDLE_LEVEL;
        pop_c   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_rdata;
                    state_d = START;
                end
            end
            START: begin
                tx_d = ~UART_IDLE_LEVEL;
                if (baud_done) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[bit_q];
                if (baud_done) begin
                    bit_d = bit_q + BIT_W'(1);
                    if (bit_last) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = even_parity(shift_q);
                if (baud_done) state_d = STOP;
            end
`endif
            STOP: begin
                // Pop on the final stop cycle so the next start bit follows with no gap.
                if (baud_done) begin
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        shift_d = fifo_rdata;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= UART_IDLE_LEVEL;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= (state_q != IDLE) || !fifo_empty;
            overflow_q <= overflow_q || (write_en && fifo_full);
        end
    end

    assign ready     = !fifo_full;
    assign tx_serial = tx_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomised checks of uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int WAIT_LIMIT = 300;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       write_en;
    logic       ready;
    logic       tx_serial;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .write_en  (write_en),
        .ready     (ready),
        .tx_serial (tx_serial),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line level of bit slot i (0 = start) for byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[3'(i - 1)];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_start(input string tag);
        int n = 0;
        while (tx_serial !== 1'b0 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, 32'(n < WAIT_LIMIT), 32'd1);
    endtask

    // Entered on the first start-bit cycle; checks every cycle of the frame.
    task automatic frame_check(input string tag, input logic [7:0] b);
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < int'(CPB); c++) begin
                check($sformatf("%s_bit%0d_c%0d", tag, i, c), 32'(tx_serial), 32'(exp_bit(b, i)));
                if (c == int'(CPB / 2) || (i == NB - 1 && c == int'(CPB) - 1))
                    check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
                @(negedge clk);
            end
        end
    endtask

    // Mid-bit sampling receiver.
    task automatic rx_byte(output logic [7:0] b);
        b = '0;
        wait_start("rx");
        repeat (CPB / 2) @(negedge clk);
        check("rx_start", 32'(tx_serial), 32'd0);
        for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clk);
            b[k] = tx_serial;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        check("rx_parity", 32'(tx_serial), 32'(^b));
`endif
        repeat (CPB) @(negedge clk);
        check("rx_stop", 32'(tx_serial), 32'd1);
    endtask

    logic [7:0] six [6];
    logic [5:0] rdy_exp;
    logic [7:0] exp_q [$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        write_en = 1'b0;
        data_in  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx_serial), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: line low two edges after the push edge.
        data_in  = 8'hA5;
        write_en = 1'b1;
        check("a5_ready", 32'(ready), 32'd1);
        @(negedge clk);
        write_en = 1'b0;
        check("a5_lat0", 32'(tx_serial), 32'd1);
        @(negedge clk);
        check("a5_lat1", 32'(tx_serial), 32'd1);
        @(negedge clk);
        frame_check("a5", 8'hA5);
        check("a5_busy_end", 32'(busy), 32'd0);
        check("a5_tx_end", 32'(tx_serial), 32'd1);
        repeat (3) @(negedge clk);

        // Three back-to-back frames.
        data_in  = 8'h00;
        write_en = 1'b1;
        @(negedge clk);
        data_in  = 8'hFF;
        @(negedge clk);
        data_in  = 8'h55;
        @(negedge clk);
        write_en = 1'b0;
        wait_start("b2b");
        frame_check("b2b_00", 8'h00);
        frame_check("b2b_ff", 8'hFF);
        frame_check("b2b_55", 8'h55);
        check("b2b_busy_end", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        // Six writes: first pops straight away, four fill the FIFO, sixth is dropped.
        six     = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66};
        rdy_exp = 6'b011111;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    data_in  = six[k];
                    write_en = 1'b1;
                    check($sformatf("ovf_ready%0d", k), 32'(ready), 32'(rdy_exp[k]));
                    @(negedge clk);
                end
                write_en = 1'b0;
                check("ovf_flag", 32'(overflow), 32'd1);
            end
            begin
                wait_start("ovf");
                for (int k = 0; k < 5; k++) frame_check($sformatf("ovf_f%0d", k), six[k]);
            end
        join
        check("ovf_busy_end", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check("ovf_no_sixth", 32'(tx_serial), 32'd1);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of data bit 0 of 8'h3C with two bytes queued.
        data_in  = 8'h3C;
        write_en = 1'b1;
        @(negedge clk);
        data_in  = 8'h81;
        @(negedge clk);
        data_in  = 8'h42;
        @(negedge clk);
        write_en = 1'b0;
        wait_start("mid");
        repeat (CPB + 1) @(negedge clk);
        check("mid_pre_tx", 32'(tx_serial), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx_serial), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int lows = 0;
            repeat (60) begin
                @(negedge clk);
                if (tx_serial !== 1'b1) lows++;
            end
            check("mid_no_frames", 32'(lows), 32'd0);
        end
        check("mid_busy_after", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
        // Parity: 8'h07 has three ones (parity 1), 8'h03 has two (parity 0).
        data_in  = 8'h07;
        write_en = 1'b1;
        @(negedge clk);
        data_in  = 8'h03;
        @(negedge clk);
        write_en = 1'b0;
        wait_start("par");
        repeat (9 * CPB) @(negedge clk);
        check("par07_bit", 32'(tx_serial), 32'd1);
        repeat (2 * CPB) @(negedge clk);
        repeat (9 * CPB) @(negedge clk);
        check("par03_bit", 32'(tx_serial), 32'd0);
        repeat (2 * CPB) @(negedge clk);
        check("par_busy_end", 32'(busy), 32'd0);
        check("par_frame_len", 32'(tx_serial), 32'd1);
        repeat (3) @(negedge clk);
`endif

        // Random bytes through the receiver model.
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    int n = 0;
                    logic [7:0] b;
                    b = 8'($urandom);
                    repeat ($urandom_range(0, 30)) @(negedge clk);
                    while (ready !== 1'b1 && n < WAIT_LIMIT * 4) begin
                        @(negedge clk);
                        n++;
                    end
                    check($sformatf("rnd_ready%0d", k), 32'(ready), 32'd1);
                    data_in  = b;
                    write_en = 1'b1;
                    exp_q.push_back(b);
                    @(negedge clk);
                    write_en = 1'b0;
                end
            end
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [7:0] r;
                    rx_byte(r);
                    if (exp_q.size() > 0)
                        check($sformatf("rnd_rx%0d", k), 32'(r), 32'(exp_q.pop_front()));
                    else
                        check($sformatf("rnd_rx%0d_unexpected", k), 32'd0, 32'd1);
                end
            end
        join
        repeat (3 * CPB) @(negedge clk);
        check("rnd_busy_end", 32'(busy), 32'd0);
        check("rnd_ovf", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
